// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcode map, ALU op codes,
// flag bit positions and the decoded control bundle.
package cu_pkg;

  localparam int unsigned OPC_W    = 4;
  localparam int unsigned ALU_OP_W = 2;
  localparam int unsigned FLG_W    = 3;
  localparam int unsigned COND_W   = 3;

  // ALU class (opcode[3] = 0): op = opcode[2:1], imm_sel = opcode[0]
  localparam logic [OPC_W-1:0] OPC_ADD_R = 4'b0000;
  localparam logic [OPC_W-1:0] OPC_ADD_I = 4'b0001;
  localparam logic [OPC_W-1:0] OPC_SUB_R = 4'b0010;
  localparam logic [OPC_W-1:0] OPC_SUB_I = 4'b0011;
  localparam logic [OPC_W-1:0] OPC_AND_R = 4'b0100;
  localparam logic [OPC_W-1:0] OPC_AND_I = 4'b0101;
  localparam logic [OPC_W-1:0] OPC_OR_R  = 4'b0110;
  localparam logic [OPC_W-1:0] OPC_OR_I  = 4'b0111;

  // Jump class (opcode[3] = 1), low three bits select the condition
  localparam logic [OPC_W-1:0] OPC_JMP   = 4'b1000;
  localparam logic [OPC_W-1:0] OPC_JZ    = 4'b1001;
  localparam logic [OPC_W-1:0] OPC_JNZ   = 4'b1010;
  localparam logic [OPC_W-1:0] OPC_JC    = 4'b1011;
  localparam logic [OPC_W-1:0] OPC_JNC   = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_JS    = 4'b1101;
  localparam logic [OPC_W-1:0] OPC_JNS   = 4'b1110;
  localparam logic [OPC_W-1:0] OPC_NOP   = 4'b1111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 2'b11;

  // Positions inside the {cf,sf,zf} flag vector
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_S = 1;
  localparam int unsigned FLG_Z = 0;

  // Decoded datapath controls
  typedef struct packed {
    logic [ALU_OP_W-1:0] op;
    logic                imm_sel;
    logic                reg_en;
    logic                jmp_sel;
  } ctrl_t;

  // ALU-class instructions are the only ones that write flags
  function automatic logic is_alu(input logic [OPC_W-1:0] opc);
    return ~opc[OPC_W-1];
  endfunction

endpackage

// File: rtl/cu_cond_eval.sv
// Branch condition evaluator.
//   cond  : opcode[2:0] of a jump-class instruction
//   flags : {C,S,Z} flag vector
//   taken : 1 when the jump condition holds (code 111 = NOP, never taken)
module cu_cond_eval
  import cu_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [FLG_W-1:0]  flags,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000:  taken = 1'b1;
      3'b001:  taken =  flags[FLG_Z];
      3'b010:  taken = ~flags[FLG_Z];
      3'b011:  taken =  flags[FLG_C];
      3'b100:  taken = ~flags[FLG_C];
      3'b101:  taken =  flags[FLG_S];
      3'b110:  taken = ~flags[FLG_S];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder, flag register and branch-condition unit.
//   clk, rst_n   : clock, async active-low reset
//   opcode       : current instruction opcode
//   cf, sf, zf   : ALU flags of the current instruction
//   imm_sel      : immediate operand / jump target select
//   reg_en       : register-file write enable (forced low in reset)
//   op           : ALU operation
//   jmp_sel      : PC load select (forced low in reset)
//   flags_q      : registered flags {cf,sf,zf}
module control_unit
  import cu_pkg::*;
#(
  parameter bit LATCH_FLAGS = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPC_W-1:0]    opcode,
  input  logic                cf,
  input  logic                sf,
  input  logic                zf,
  output logic                imm_sel,
  output logic                reg_en,
  output logic [ALU_OP_W-1:0] op,
  output logic                jmp_sel,
  output logic [FLG_W-1:0]    flags_q
);

  logic [FLG_W-1:0] flags_in;
  logic [FLG_W-1:0] cond_flags;
  logic             cond_taken;
  ctrl_t            ctrl;

  assign flags_in = {cf, sf, zf};

  // Flag register: written only by ALU-class instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (is_alu(opcode)) begin
      flags_q <= flags_in;
    end
  end

  // Condition source: registered flags or the live ALU flags
  assign cond_flags = LATCH_FLAGS ? flags_q : flags_in;

  cu_cond_eval u_cond_eval (
    .cond  (opcode[COND_W-1:0]),
    .flags (cond_flags),
    .taken (cond_taken)
  );

  // Combinational decode
  always_comb begin
    ctrl = '0;
    if (is_alu(opcode)) begin
      ctrl.op      = opcode[2:1];
      ctrl.imm_sel = opcode[0];
      ctrl.reg_en  = 1'b1;
    end else if (opcode != OPC_NOP) begin
      ctrl.op      = ALU_ADD;
      ctrl.imm_sel = 1'b1;
      ctrl.jmp_sel = cond_taken;
    end
  end

  // Side-effecting controls are suppressed while reset is asserted
  assign op      = ctrl.op;
  assign imm_sel = ctrl.imm_sel;
  assign reg_en  = ctrl.reg_en  & rst_n;
  assign jmp_sel = ctrl.jmp_sel & rst_n;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; a latched-flag and a
// raw-flag instance share all inputs.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       cf, sf, zf;

  logic       l_imm, l_reg, l_jmp;
  logic [1:0] l_op;
  logic [2:0] l_flags;
  logic       r_imm, r_reg, r_jmp;
  logic [1:0] r_op;
  logic [2:0] r_flags;

  int checks;
  int errors;

  control_unit #(.LATCH_FLAGS(1'b1)) u_lat (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cf(cf), .sf(sf), .zf(zf),
    .imm_sel(l_imm), .reg_en(l_reg), .op(l_op), .jmp_sel(l_jmp),
    .flags_q(l_flags)
  );

  control_unit #(.LATCH_FLAGS(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cf(cf), .sf(sf), .zf(zf),
    .imm_sel(r_imm), .reg_en(r_reg), .op(r_op), .jmp_sel(r_jmp),
    .flags_q(r_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {op, imm_sel, reg_en, jmp_sel} of the latched instance
  logic [4:0] l_ctrl;
  assign l_ctrl = {l_op, l_imm, l_reg, l_jmp};

  task automatic test_reset();
    rst_n = 1'b0; opcode = 4'b0000; cf = 1'b0; sf = 1'b0; zf = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (l_ctrl !== 5'b00_0_0_0) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", l_ctrl, 5'b00000);
    end
    checks++;
    if (l_flags !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp %b", l_flags, 3'b000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (l_ctrl !== 5'b00_0_1_0) begin
      errors++; $display("FAIL release_add_r got %b exp %b", l_ctrl, 5'b00010);
    end
  endtask

  task automatic test_alu_decode();
    logic [3:0] opc [8];
    logic [4:0] exp [8];
    opc = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111};
    exp = '{5'b00_0_1_0, 5'b00_1_1_0, 5'b01_0_1_0, 5'b01_1_1_0,
            5'b10_0_1_0, 5'b10_1_1_0, 5'b11_0_1_0, 5'b11_1_1_0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      opcode = opc[i];
      #1;
      checks++;
      if (l_ctrl !== exp[i]) begin
        errors++; $display("FAIL alu_decode opc=%b got %b exp %b", opc[i], l_ctrl, exp[i]);
      end
    end
  endtask

  task automatic test_jmp_nop();
    @(negedge clk);
    opcode = 4'b0000; cf = 1'b0; sf = 1'b0; zf = 1'b0;
    @(negedge clk);
    opcode = 4'b1000;
    #1;
    checks++;
    if (l_ctrl !== 5'b00_1_0_1) begin
      errors++; $display("FAIL jmp got %b exp %b", l_ctrl, 5'b00101);
    end
    opcode = 4'b1111;
    #1;
    checks++;
    if (l_ctrl !== 5'b00_0_0_0) begin
      errors++; $display("FAIL nop got %b exp %b", l_ctrl, 5'b00000);
    end
  endtask

  task automatic test_flag_latch_jz();
    @(negedge clk);
    opcode = 4'b0010; zf = 1'b1; cf = 1'b0; sf = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (l_flags !== 3'b001) begin
      errors++; $display("FAIL latch_flags got %b exp %b", l_flags, 3'b001);
    end
    opcode = 4'b1001; zf = 1'b0;
    #1;
    checks++;
    if (l_jmp !== 1'b1) begin
      errors++; $display("FAIL jz_latched got %b exp %b", l_jmp, 1'b1);
    end
    checks++;
    if (r_jmp !== 1'b0) begin
      errors++; $display("FAIL jz_raw got %b exp %b", r_jmp, 1'b0);
    end
    checks++;
    if (r_flags !== 3'b001) begin
      errors++; $display("FAIL raw_flags got %b exp %b", r_flags, 3'b001);
    end
  endtask

  task automatic test_flag_hold();
    @(negedge clk);
    opcode = 4'b1001; cf = 1'b1; sf = 1'b1; zf = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (l_flags !== 3'b001) begin
      errors++; $display("FAIL hold_flags got %b exp %b", l_flags, 3'b001);
    end
    opcode = 4'b1101;
    #1;
    checks++;
    if (l_jmp !== 1'b0) begin
      errors++; $display("FAIL js_latched got %b exp %b", l_jmp, 1'b0);
    end
    checks++;
    if (r_jmp !== 1'b1) begin
      errors++; $display("FAIL js_raw got %b exp %b", r_jmp, 1'b1);
    end
    opcode = 4'b1110;
    #1;
    checks++;
    if (l_jmp !== 1'b1) begin
      errors++; $display("FAIL jns_latched got %b exp %b", l_jmp, 1'b1);
    end
    checks++;
    if (r_jmp !== 1'b0) begin
      errors++; $display("FAIL jns_raw got %b exp %b", r_jmp, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    opcode = 4'b0001; cf = 1'b1; sf = 1'b0; zf = 1'b0;
    @(negedge clk);
    opcode = 4'b0110; cf = 1'b0; sf = 1'b1; zf = 1'b1;
    @(negedge clk);
    opcode = 4'b1011; cf = 1'b1; sf = 1'b0; zf = 1'b0;
    #1;
    checks++;
    if (l_flags !== 3'b011) begin
      errors++; $display("FAIL b2b_flags got %b exp %b", l_flags, 3'b011);
    end
    checks++;
    if (l_jmp !== 1'b0) begin
      errors++; $display("FAIL b2b_jc got %b exp %b", l_jmp, 1'b0);
    end
    opcode = 4'b1010;
    #1;
    checks++;
    if (l_jmp !== 1'b0) begin
      errors++; $display("FAIL b2b_jnz got %b exp %b", l_jmp, 1'b0);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    opcode = 4'b0000; cf = 1'b1; sf = 1'b1; zf = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (l_flags !== 3'b110) begin
      errors++; $display("FAIL pre_reset_flags got %b exp %b", l_flags, 3'b110);
    end
    opcode = 4'b1011;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (l_flags !== 3'b000) begin
      errors++; $display("FAIL async_flags got %b exp %b", l_flags, 3'b000);
    end
    // Jump decode keeps op/imm_sel but loses reg_en/jmp_sel
    checks++;
    if (l_ctrl !== 5'b00_1_0_0) begin
      errors++; $display("FAIL async_ctrl got %b exp %b", l_ctrl, 5'b00100);
    end
    opcode = 4'b0000;
    @(negedge clk);
    #1;
    checks++;
    if (l_flags !== 3'b000) begin
      errors++; $display("FAIL reset_hold_flags got %b exp %b", l_flags, 3'b000);
    end
    checks++;
    if (l_reg !== 1'b0) begin
      errors++; $display("FAIL reset_reg_en got %b exp %b", l_reg, 1'b0);
    end
    rst_n = 1'b1; cf = 1'b0; sf = 1'b0; zf = 1'b0;
    opcode = 4'b1011;
    #1;
    checks++;
    if (l_jmp !== 1'b0) begin
      errors++; $display("FAIL post_reset_jc got %b exp %b", l_jmp, 1'b0);
    end
    opcode = 4'b1100;
    #1;
    checks++;
    if (l_jmp !== 1'b1) begin
      errors++; $display("FAIL post_reset_jnc got %b exp %b", l_jmp, 1'b1);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_alu_decode();
    test_jmp_nop();
    test_flag_latch_jz();
    test_flag_hold();
    test_back_to_back();
    test_async_reset();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
